// File: rtl/crc16_t_if.sv
// crc16_t_if: byte-stream handshake bundle used on both sides of the
// DATA-packet framer (link-layer input tx_ld, TX-mux output tx_lt).
//   sop    first byte of packet
//   eop    last byte of packet
//   valid  byte valid
//   ready  byte accepted when valid & ready
//   data   byte
//   cancle abort marker. The framer only reads it on its input side when
//          CRC16_T_CANCEL_EN is defined. It always drives it on its output
//          side, where it stays 0 unless that macro is defined.
// master drives the stream; slave accepts it.
interface crc16_t_if;
  logic       sop;
  logic       eop;
  logic       valid;
  logic       ready;
  logic [7:0] data;
  logic       cancle;

  modport master (output sop, eop, valid, data, cancle, input ready);
  modport slave  (input sop, eop, valid, data, cancle, output ready);
endinterface

// File: rtl/crc16_t.sv
// crc16_t: TX DATA-packet framer.
// It passes the PID through and runs USB CRC16 over the payload bytes. It
// then appends ~crc as two bytes, low byte first. EOP moves onto the last
// CRC byte.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   tx_ld     input byte stream from the link layer (slave)
//   tx_lt     output byte stream to the TX mux (master), one register slot
//   pkt_len   payload length of the last completed packet
//   pkt_err   one-cycle pulse on a framing or length error
// Optional: defining CRC16_T_CANCEL_EN honours tx_ld.cancle in PAYLOAD.
// A cancelled beat goes out with cancle=1 and eop=1, and no CRC follows.
module crc16_t #(
  parameter int MAX_PAYLOAD = 1023,
  parameter int LEN_W       = 11
) (
  input  logic             clk,
  input  logic             rst,
  crc16_t_if.slave         tx_ld,
  crc16_t_if.master        tx_lt,
  output logic [LEN_W-1:0] pkt_len,
  output logic             pkt_err
);

  typedef enum logic [1:0] {IDLE, PAYLOAD, CRC_LO, CRC_HI} state_t;

  state_t           state, state_n;
  logic [15:0]      crc, crc_n;
  logic [LEN_W-1:0] len, len_n, pkt_len_n;
  logic             slot_free, accept, load;
  logic             nx_sop, nx_eop, nx_err;
  logic [7:0]       nx_data;
`ifdef CRC16_T_CANCEL_EN
  logic             nx_can;
`endif

  // Reflected poly 0x8005 (0xA001), one byte per call, LSB first.
  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    return r;
  endfunction

  assign slot_free   = ~tx_lt.valid | tx_lt.ready;
  assign tx_ld.ready = slot_free & ((state == IDLE) | (state == PAYLOAD));
  assign accept      = tx_ld.valid & tx_ld.ready;

  always_comb begin
    state_n   = state;
    crc_n     = crc;
    len_n     = len;
    pkt_len_n = pkt_len;
    load      = 1'b0;
    nx_sop    = 1'b0;
    nx_eop    = 1'b0;
    nx_data   = tx_ld.data;
    nx_err    = 1'b0;
`ifdef CRC16_T_CANCEL_EN
    nx_can    = 1'b0;
`endif
    case (state)
      IDLE: if (accept) begin
        if (tx_ld.sop) begin
          load    = 1'b1;
          nx_sop  = 1'b1;
          crc_n   = 16'hFFFF;
          len_n   = '0;
          state_n = tx_ld.eop ? CRC_LO : PAYLOAD;
        end else begin
          nx_err  = 1'b1;  // stray beat outside a packet: dropped
        end
      end
      PAYLOAD: if (accept) begin
        load   = 1'b1;
        crc_n  = crc_upd(crc, tx_ld.data);
        len_n  = (len == {LEN_W{1'b1}}) ? len : len + LEN_W'(1);
        // A mid-packet SOP is carried as payload. Crossing MAX_PAYLOAD
        // flags once. Both cases still frame the packet normally.
        nx_err = tx_ld.sop | (len == LEN_W'(MAX_PAYLOAD));
`ifdef CRC16_T_CANCEL_EN
        if (tx_ld.cancle) begin
          nx_can  = 1'b1;
          nx_eop  = 1'b1;
          state_n = IDLE;
        end else
`endif
        if (tx_ld.eop) state_n = CRC_LO;
      end
      CRC_LO: if (slot_free) begin
        load    = 1'b1;
        nx_data = ~crc[7:0];
        state_n = CRC_HI;
      end
      CRC_HI: if (slot_free) begin
        load      = 1'b1;
        nx_data   = ~crc[15:8];
        nx_eop    = 1'b1;
        pkt_len_n = len;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      crc     <= 16'hFFFF;
      len     <= '0;
      pkt_len <= '0;
      pkt_err <= 1'b0;
    end else begin
      state   <= state_n;
      crc     <= crc_n;
      len     <= len_n;
      pkt_len <= pkt_len_n;
      pkt_err <= nx_err;
    end
  end

  // Output slot: it loads only while free. It otherwise holds every field.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_lt.valid  <= 1'b0;
      tx_lt.sop    <= 1'b0;
      tx_lt.eop    <= 1'b0;
      tx_lt.data   <= 8'h00;
`ifdef CRC16_T_CANCEL_EN
      tx_lt.cancle <= 1'b0;
`endif
    end else if (load) begin
      tx_lt.valid  <= 1'b1;
      tx_lt.sop    <= nx_sop;
      tx_lt.eop    <= nx_eop;
      tx_lt.data   <= nx_data;
`ifdef CRC16_T_CANCEL_EN
      tx_lt.cancle <= nx_can;
`endif
    end else if (tx_lt.ready) begin
      tx_lt.valid  <= 1'b0;
    end
  end

`ifndef CRC16_T_CANCEL_EN
  assign tx_lt.cancle = 1'b0;
`endif

endmodule

// File: tb/tb_crc16_t.sv
module tb_crc16_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] pkt_len;
  logic        pkt_err;

  always #5 clk = ~clk;

  crc16_t_if tx_ld();
  crc16_t_if tx_lt();

  crc16_t #(.MAX_PAYLOAD(1023), .LEN_W(11)) dut (
    .clk(clk), .rst(rst), .tx_ld(tx_ld), .tx_lt(tx_lt),
    .pkt_len(pkt_len), .pkt_err(pkt_err)
  );

  typedef struct {
    logic       in_vld, in_sop, in_eop, in_can;
    logic [7:0] in_data;
    logic       out_sop, out_eop, out_can;
    logic [7:0] out_data;
  } vec_t;
  typedef struct { logic sop, eop, can; logic [7:0] data; } beat_t;

  vec_t  tbl[$];
  beat_t obs[$];
  int    checks = 0, passes = 0, err_cnt = 0, cyc = 0;
  bit    toggle_mode = 0;
  bit    prev_stall = 0;
  logic [7:0] prev_data = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    checks++;
    $display("FAIL %s: timed out", name);
  endtask

  function automatic vec_t mk(input logic vld, isop, ieop, input logic [7:0] idata,
                              input logic osop, oeop, input logic [7:0] odata);
    vec_t v;
    v.in_vld = vld; v.in_sop = isop; v.in_eop = ieop; v.in_can = 1'b0; v.in_data = idata;
    v.out_sop = osop; v.out_eop = oeop; v.out_can = 1'b0; v.out_data = odata;
    return v;
  endfunction

  // Ready pattern 1,0,0,1 when toggling; all changes at negedge.
  always @(negedge clk) begin
    cyc++;
    tx_lt.ready = toggle_mode ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
  end

  // Output monitor: values at negedge+2 are what the next posedge transfers.
  always begin
    @(negedge clk);
    #2;
    if (prev_stall) chk("stall hold", {tx_lt.valid, tx_lt.data}, {1'b1, prev_data});
    prev_stall = tx_lt.valid && !tx_lt.ready;
    prev_data  = tx_lt.data;
    if (tx_lt.valid && tx_lt.ready)
      obs.push_back('{sop: tx_lt.sop, eop: tx_lt.eop, can: tx_lt.cancle, data: tx_lt.data});
    if (pkt_err) err_cnt++;
  end

  // Entered just after a negedge; returns just after the accepting edge.
  task automatic send(input logic sop, input logic eop, input logic can, input logic [7:0] d);
    int n = 0;
    bit acc;
    tx_ld.sop = sop; tx_ld.eop = eop; tx_ld.cancle = can; tx_ld.data = d; tx_ld.valid = 1'b1;
    forever begin
      #1;
      acc = tx_ld.ready;
      @(negedge clk);
      if (acc) break;
      n++;
      if (n > 200) begin timeout("send"); break; end
    end
    tx_ld.valid = 1'b0; tx_ld.cancle = 1'b0;
  endtask

  task automatic wait_obs(input int n, input int budget);
    int k = 0;
    while (obs.size() < n && k < budget) begin @(negedge clk); k++; end
    if (obs.size() < n) timeout("drain");
    repeat (4) @(negedge clk);
  endtask

  task automatic run_tbl(input string name, input logic [10:0] exp_len);
    int e0 = err_cnt;
    obs.delete();
    foreach (tbl[i]) if (tbl[i].in_vld) send(tbl[i].in_sop, tbl[i].in_eop, tbl[i].in_can, tbl[i].in_data);
    wait_obs(tbl.size(), 300);
    chk({name, " beats"}, obs.size(), tbl.size());
    for (int i = 0; i < tbl.size() && i < obs.size(); i++)
      chk($sformatf("%s beat%0d", name, i),
          {obs[i].sop, obs[i].eop, obs[i].can, obs[i].data},
          {tbl[i].out_sop, tbl[i].out_eop, tbl[i].out_can, tbl[i].out_data});
    chk({name, " pkt_len"}, pkt_len, exp_len);
    chk({name, " no err"}, err_cnt, e0);
  endtask

  task automatic load_std;
    tbl.delete();
    tbl.push_back(mk(1, 1, 0, 8'hC3, 1, 0, 8'hC3));
    for (int b = 8'h31; b <= 8'h38; b++) tbl.push_back(mk(1, 0, 0, 8'(b), 0, 0, 8'(b)));
    tbl.push_back(mk(1, 0, 1, 8'h39, 0, 0, 8'h39));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 8'hC8));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 1, 8'hB4));
  endtask

  task automatic load_zero;
    tbl.delete();
    tbl.push_back(mk(1, 1, 1, 8'h4B, 1, 0, 8'h4B));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 8'h00));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 1, 8'h00));
  endtask

  task automatic big_pkt(input int n, input int exp_err);
    int e0 = err_cnt;
    obs.delete();
    send(1'b1, 1'b0, 1'b0, 8'hC3);
    for (int i = 0; i < n; i++) send(1'b0, (i == n - 1), 1'b0, 8'(i));
    wait_obs(n + 3, 100);
    chk($sformatf("big%0d beats", n), obs.size(), n + 3);
    if (obs.size() > 0) chk($sformatf("big%0d last eop", n), obs[obs.size()-1].eop, 1'b1);
    chk($sformatf("big%0d pkt_len", n), pkt_len, n);
    chk($sformatf("big%0d err pulses", n), err_cnt - e0, exp_err);
  endtask

  initial begin
    int e0;
    tx_ld.valid = 0; tx_ld.sop = 0; tx_ld.eop = 0; tx_ld.data = 0; tx_ld.cancle = 0;
    tx_lt.ready = 1;
    repeat (3) @(negedge clk);
    #2;
    chk("rst valid", tx_lt.valid, 0);
    chk("rst sop/eop", {tx_lt.sop, tx_lt.eop}, 0);
    chk("rst data", tx_lt.data, 0);
    chk("rst cancle", tx_lt.cancle, 0);
    chk("rst pkt_len", pkt_len, 0);
    chk("rst pkt_err", pkt_err, 0);
    @(negedge clk); rst = 0;
    @(negedge clk);

    load_std();  run_tbl("std", 11'd9);
    load_zero(); run_tbl("zero", 11'd0);
    toggle_mode = 1;
    load_std();  run_tbl("toggle", 11'd9);
    toggle_mode = 0;
    repeat (3) @(negedge clk);

    // Stray non-SOP beat in IDLE.
    obs.delete(); e0 = err_cnt;
    send(1'b0, 1'b0, 1'b0, 8'h55);
    repeat (4) @(negedge clk);
    chk("stray err pulse", err_cnt - e0, 1);
    chk("stray no output", obs.size(), 0);
    load_zero(); run_tbl("after stray", 11'd0);

    // Reset in the middle of a packet.
    send(1'b1, 1'b0, 1'b0, 8'hC3);
    send(1'b0, 1'b0, 1'b0, 8'h31);
    send(1'b0, 1'b0, 1'b0, 8'h32);
    send(1'b0, 1'b0, 1'b0, 8'h33);
    rst = 1;
    @(negedge clk); #2;
    chk("midrst outs", {tx_lt.valid, tx_lt.sop, tx_lt.eop, tx_lt.data, tx_lt.cancle}, 0);
    chk("midrst pkt_len", pkt_len, 0);
    chk("midrst pkt_err", pkt_err, 0);
    @(negedge clk); rst = 0;
    @(negedge clk);
    tbl.delete();
    tbl.push_back(mk(1, 1, 0, 8'hC3, 1, 0, 8'hC3));
    for (int b = 0; b < 4; b++) tbl.push_back(mk(1, 0, (b == 3), 8'(b), 0, 0, 8'(b)));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 8'hEF));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 1, 8'h7A));
    run_tbl("after rst", 11'd4);

`ifdef CRC16_T_CANCEL_EN
    tbl.delete();
    tbl.push_back(mk(1, 1, 0, 8'hC3, 1, 0, 8'hC3));
    tbl.push_back(mk(1, 0, 0, 8'h11, 0, 0, 8'h11));
    tbl.push_back(mk(1, 0, 0, 8'h22, 0, 1, 8'h22));
    tbl[2].in_can = 1'b1; tbl[2].out_can = 1'b1;
    run_tbl("cancel", 11'd4);
`endif

    // Length boundary: MAX_PAYLOAD is legal, one more byte flags once.
    big_pkt(1023, 0);
    big_pkt(1024, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
